seg7_decode_monitor: RTL and testbench

//  Receive-side counterpart of the 7-segment digit driver: samples a 7-segment pattern bus, filters

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/seg7_stability_filter.sv | 39 +++
 rtl/seg7_decode_monitor.sv | 95 +++++++++
 tb/tb_seg7_decode_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns, monitor state encoding and the pattern decoder.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  // Segment order is {a,b,c,d,e,f,g}, active-high
  localparam logic [SEG_W-1:0] SEG_0     = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h70;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h7B;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_BAD    = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic             valid;
    logic             blank;
    logic [BCD_W-1:0] digit;
  } seg7_dec_t;

  // Map a segment pattern to {valid, blank, digit}; unknown patterns give all zeros
  function automatic seg7_dec_t seg7_to_bcd(input logic [SEG_W-1:0] pattern);
    seg7_dec_t r;
    r = '0;
    case (pattern)
      SEG_0:     begin r.valid = 1'b1; r.digit = 4'd0; end
      SEG_1:     begin r.valid = 1'b1; r.digit = 4'd1; end
      SEG_2:     begin r.valid = 1'b1; r.digit = 4'd2; end
      SEG_3:     begin r.valid = 1'b1; r.digit = 4'd3; end
      SEG_4:     begin r.valid = 1'b1; r.digit = 4'd4; end
      SEG_5:     begin r.valid = 1'b1; r.digit = 4'd5; end
      SEG_6:     begin r.valid = 1'b1; r.digit = 4'd6; end
      SEG_7:     begin r.valid = 1'b1; r.digit = 4'd7; end
      SEG_8:     begin r.valid = 1'b1; r.digit = 4'd8; end
      SEG_9:     begin r.valid = 1'b1; r.digit = 4'd9; end
      SEG_BLANK: r.blank = 1'b1;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_stability_filter.sv
// One-stage input sync plus a run-length filter; flags the edge on which a pattern becomes settled.
module seg7_stability_filter
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_in,
  output logic             accept_c,
  output logic [SEG_W-1:0] pattern
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SEG_W-1:0] seg_sync;
  logic [CNT_W-1:0] cnt;

  // Sync stage, candidate capture and saturating run counter
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_sync <= '0;
      pattern  <= '0;
      cnt      <= '0;
    end else begin
      seg_sync <= seg_in;
      if (seg_sync != pattern) begin
        pattern <= seg_sync;
        cnt     <= CNT_W'(1);
      end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // High during the cycle whose closing edge takes cnt to STABLE_CYCLES
  assign accept_c = (seg_sync == pattern) && (cnt == CNT_W'(STABLE_CYCLES - 1));

endmodule

// File: rtl/seg7_decode_monitor.sv
// Decodes settled 7-segment patterns to BCD and checks the 0..9 wrap-around digit sequence.
module seg7_decode_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8,
  parameter int unsigned CHECK_SEQ     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             blank,
  output logic             new_digit,
  output logic             invalid,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic             accept_c;
  logic [SEG_W-1:0] filt_pat;
  logic [SEG_W-1:0] acc_pat;
  logic             acc_vld;
  mon_state_t       state;
  seg7_dec_t        dec_c;
  logic [3:0]       expect_c;
  logic             event_c;

  seg7_stability_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .accept_c(accept_c),
    .pattern (filt_pat)
  );

  // Decode of the candidate pattern, expected successor digit, and new-event qualifier
  always_comb begin
    dec_c    = seg7_to_bcd(filt_pat);
    expect_c = (digit_out == 4'd9) ? 4'd0 : (digit_out + 4'd1);
    event_c  = accept_c && !(acc_vld && (filt_pat == acc_pat));
  end

  // Monitor FSM with registered flags, pulses and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc_pat     <= '0;
      acc_vld     <= 1'b0;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      new_digit   <= 1'b0;
      invalid     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      new_digit <= 1'b0;
      invalid   <= 1'b0;
      seq_err   <= 1'b0;
      if (event_c) begin
        acc_pat <= filt_pat;
        acc_vld <= 1'b1;
        if (dec_c.valid) begin
          digit_out   <= dec_c.digit;
          digit_valid <= 1'b1;
          blank       <= 1'b0;
          new_digit   <= 1'b1;
          state       <= ST_LOCKED;
          // Only a locked reference is checked; IDLE/BAD resynchronise silently
          if ((state == ST_LOCKED) && (CHECK_SEQ != 0) && (dec_c.digit != expect_c)) begin
            seq_err <= 1'b1;
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          end
        end else if (dec_c.blank) begin
          blank       <= 1'b1;
          digit_valid <= 1'b0;
          state       <= ST_BAD;
        end else begin
          invalid     <= 1'b1;
          digit_valid <= 1'b0;
          blank       <= 1'b0;
          state       <= ST_BAD;
          if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Directed self-checking bench for seg7_decode_monitor (default build plus a 2-bit error counter build).
module tb_seg7_decode_monitor;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;

  logic [3:0] digit_out, digit_out2;
  logic       digit_valid, digit_valid2;
  logic       blank, blank2;
  logic       new_digit, new_digit2;
  logic       invalid, invalid2;
  logic       seq_err, seq_err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int tests;
  int fails;

  seg7_decode_monitor #(.STABLE_CYCLES(4), .ERR_W(8), .CHECK_SEQ(1)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in),
    .digit_out(digit_out), .digit_valid(digit_valid), .blank(blank),
    .new_digit(new_digit), .invalid(invalid), .seq_err(seq_err), .err_count(err_count)
  );

  seg7_decode_monitor #(.STABLE_CYCLES(4), .ERR_W(2), .CHECK_SEQ(1)) dut2 (
    .clk(clk), .rst(rst), .seg_in(seg_in),
    .digit_out(digit_out2), .digit_valid(digit_valid2), .blank(blank2),
    .new_digit(new_digit2), .invalid(invalid2), .seq_err(seq_err2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a pattern for n edges, counting output pulses of the main instance
  task automatic hold(input logic [6:0] p, input int n,
                      output int nd, output int inv, output int se, output int both, output int inv2);
    nd = 0; inv = 0; se = 0; both = 0; inv2 = 0;
    seg_in = p;
    for (int i = 0; i < n; i++) begin
      tick();
      nd   += int'(new_digit);
      inv  += int'(invalid);
      se   += int'(seq_err);
      both += int'(new_digit && seq_err);
      inv2 += int'(invalid2);
    end
  endtask

  task automatic do_reset(input logic [6:0] p);
    rst    = 1'b1;
    seg_in = 7'h00;
    tick();
    tick();
    rst    = 1'b0;
    seg_in = p;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    rst    = 1'b1;
    seg_in = 7'h7E;
    tick();
    tick();
    obs = {digit_out, digit_valid, blank, new_digit, invalid, seq_err, err_count};
    tests++;
    if (obs !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 17'd0);
    end
    rst = 1'b0;
    // Pattern present before edge 1 appears after edge 5
    for (int e = 1; e <= 6; e++) begin
      tick();
      tests++;
      if (new_digit !== ((e == 5) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL first_accept_edge%0d new_digit got=%b exp=%b", e, new_digit, (e == 5));
      end
    end
    tests++;
    if (digit_out !== 4'd0 || digit_valid !== 1'b1 || err_count !== 8'd0) begin
      fails++;
      $display("FAIL first_digit got d=%0d v=%b err=%0d exp d=0 v=1 err=0", digit_out, digit_valid, err_count);
    end
  endtask

  task automatic test_sequence();
    logic [6:0] pats [0:10];
    int nd, inv, se, both, inv2;
    int total_nd, total_se;
    pats = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h7E};
    do_reset(7'h7E);
    total_nd = 0;
    total_se = 0;
    for (int i = 0; i < 11; i++) begin
      hold(pats[i], 10, nd, inv, se, both, inv2);
      total_nd += nd;
      total_se += se;
      tests++;
      if (digit_out !== 4'((i == 10) ? 0 : i)) begin
        fails++;
        $display("FAIL seq_digit step%0d got=%0d exp=%0d", i, digit_out, (i == 10) ? 0 : i);
      end
    end
    tests++;
    if (total_nd !== 11 || total_se !== 0 || err_count !== 8'd0) begin
      fails++;
      $display("FAIL seq_counts got nd=%0d se=%0d err=%0d exp nd=11 se=0 err=0", total_nd, total_se, err_count);
    end
  endtask

  task automatic test_glitch();
    int nd, inv, se, both, inv2;
    do_reset(7'h79);
    hold(7'h79, 10, nd, inv, se, both, inv2);
    tests++;
    if (nd !== 1 || digit_out !== 4'd3) begin
      fails++;
      $display("FAIL glitch_setup got nd=%0d d=%0d exp nd=1 d=3", nd, digit_out);
    end
    hold(7'h7F, 1, nd, inv, se, both, inv2);
    hold(7'h79, 10, nd, inv, se, both, inv2);
    tests++;
    if (nd !== 0 || digit_out !== 4'd3 || digit_valid !== 1'b1 || inv !== 0) begin
      fails++;
      $display("FAIL glitch_hold got nd=%0d d=%0d v=%b inv=%0d exp nd=0 d=3 v=1 inv=0", nd, digit_out, digit_valid, inv);
    end
  endtask

  task automatic test_seq_err();
    int nd, inv, se, both, inv2;
    do_reset(7'h6D);
    hold(7'h6D, 10, nd, inv, se, both, inv2);
    hold(7'h5B, 10, nd, inv, se, both, inv2);
    tests++;
    if (both !== 1 || se !== 1 || digit_out !== 4'd5 || err_count !== 8'd1) begin
      fails++;
      $display("FAIL seq_err got both=%0d se=%0d d=%0d err=%0d exp both=1 se=1 d=5 err=1", both, se, digit_out, err_count);
    end
  endtask

  task automatic test_invalid_blank();
    int nd, inv, se, both, inv2;
    hold(7'h01, 10, nd, inv, se, both, inv2);
    tests++;
    if (inv !== 1 || digit_valid !== 1'b0 || blank !== 1'b0 || digit_out !== 4'd5 || err_count !== 8'd2) begin
      fails++;
      $display("FAIL invalid got inv=%0d v=%b b=%b d=%0d err=%0d exp inv=1 v=0 b=0 d=5 err=2",
               inv, digit_valid, blank, digit_out, err_count);
    end
    hold(7'h30, 10, nd, inv, se, both, inv2);
    tests++;
    if (nd !== 1 || se !== 0 || digit_out !== 4'd1 || digit_valid !== 1'b1 || err_count !== 8'd2) begin
      fails++;
      $display("FAIL resync got nd=%0d se=%0d d=%0d v=%b err=%0d exp nd=1 se=0 d=1 v=1 err=2",
               nd, se, digit_out, digit_valid, err_count);
    end
    hold(7'h00, 10, nd, inv, se, both, inv2);
    tests++;
    if (blank !== 1'b1 || digit_valid !== 1'b0 || digit_out !== 4'd1 || inv !== 0 || nd !== 0 || err_count !== 8'd2) begin
      fails++;
      $display("FAIL blank got b=%b v=%b d=%0d inv=%0d nd=%0d err=%0d exp b=1 v=0 d=1 inv=0 nd=0 err=2",
               blank, digit_valid, digit_out, inv, nd, err_count);
    end
    // Any digit after blank resynchronises without a sequence error
    hold(7'h5F, 10, nd, inv, se, both, inv2);
    tests++;
    if (nd !== 1 || se !== 0 || blank !== 1'b0 || digit_out !== 4'd6) begin
      fails++;
      $display("FAIL after_blank got nd=%0d se=%0d b=%b d=%0d exp nd=1 se=0 b=0 d=6", nd, se, blank, digit_out);
    end
  endtask

  task automatic test_saturate();
    int nd, inv, se, both, inv2;
    int total2;
    logic [6:0] bad [0:4];
    bad = '{7'h01, 7'h02, 7'h01, 7'h02, 7'h01};
    do_reset(7'h01);
    total2 = 0;
    for (int i = 0; i < 5; i++) begin
      hold(bad[i], 10, nd, inv, se, both, inv2);
      total2 += inv2;
    end
    tests++;
    if (err_count2 !== 2'd3 || total2 !== 5) begin
      fails++;
      $display("FAIL err_saturate got err2=%0d inv2=%0d exp err2=3 inv2=5", err_count2, total2);
    end
    tests++;
    if (err_count !== 8'd5) begin
      fails++;
      $display("FAIL err_count8 got=%0d exp=5", err_count);
    end
  endtask

  task automatic test_mid_reset();
    logic [16:0] obs;
    int nd, inv, se, both, inv2;
    // Reset coincident with a new_digit pulse
    hold(7'h30, 5, nd, inv, se, both, inv2);
    tests++;
    if (new_digit !== 1'b1) begin
      fails++;
      $display("FAIL mid_pulse_setup new_digit got=%b exp=1", new_digit);
    end
    rst = 1'b1;
    tick();
    obs = {digit_out, digit_valid, blank, new_digit, invalid, seq_err, err_count};
    tests++;
    if (obs !== 17'd0 || err_count2 !== 2'd0) begin
      fails++;
      $display("FAIL mid_pulse_reset got=%h err2=%0d exp=0", obs, err_count2);
    end
    rst = 1'b0;
    // Reset part-way through filtering a new pattern
    hold(7'h6D, 3, nd, inv, se, both, inv2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold(7'h6D, 2, nd, inv, se, both, inv2);
    obs = {digit_out, digit_valid, blank, new_digit, invalid, seq_err, err_count};
    tests++;
    if (obs !== 17'd0 || nd !== 0) begin
      fails++;
      $display("FAIL mid_filter_reset got=%h nd=%0d exp=0 nd=0", obs, nd);
    end
    // Filter restarted from scratch: pattern present since reset release lands after edge 5
    hold(7'h6D, 3, nd, inv, se, both, inv2);
    tests++;
    if (nd !== 1 || digit_out !== 4'd2) begin
      fails++;
      $display("FAIL post_reset_accept got nd=%0d d=%0d exp nd=1 d=2", nd, digit_out);
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    seg_in = 7'h00;
    test_reset();
    test_sequence();
    test_glitch();
    test_seq_err();
    test_invalid_blank();
    test_saturate();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
